// File: rtl/seg7_serial_tx.sv
// Serializer for an 8-digit, active-low 7-segment display behind a 64-bit shift register.
// Frames are sent MSB first with a programmable shift clock, then latched.
module seg7_serial_tx #(
    parameter int CLK_DIV   = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  LE_in,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_latch,
    output logic        seg_clrn,
    output logic        busy,
    output logic        done
);

    localparam int           BW         = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [7:0]   DIV_LAST   = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t         state_q;
    logic [63:0]    frame_q, frame_d;
    logic [7:0]     div_q;
    logic [5:0]     bit_q;
    logic [BW-1:0]  blink_cnt_q;
    logic           blink_q;
    logic           seg_clk_q, seg_sout_q, seg_latch_q, seg_clrn_q, busy_q, done_q;

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        // NOTE: default assignment first so no path leaves frame_d unassigned (no latch).
        frame_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (LE_in[i] && blink_q)
                frame_d[8*i +: 8] = 8'hFF;
            else
                frame_d[8*i +: 8] = {~point_in[i], hex_to_seg(Disp_num[4*i +: 4])};
        end
    end

    // Free-running blink phase, independent of frame activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            seg_clk_q   <= 1'b0;
            seg_sout_q  <= 1'b1;
            seg_latch_q <= 1'b0;
            seg_clrn_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            seg_clrn_q <= 1'b1;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    // frame_q holds the not-yet-sent bits, next bit always at [63].
                    frame_q    <= {frame_d[62:0], 1'b0};
                    seg_sout_q <= frame_d[63];
                    div_q      <= '0;
                    bit_q      <= '0;
                    state_q    <= SHIFT;
                end
                SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        if (!seg_clk_q) begin
                            seg_clk_q <= 1'b1;
                        end else begin
                            seg_clk_q <= 1'b0;
                            if (bit_q == 6'd63) begin
                                state_q     <= LATCH;
                                seg_sout_q  <= 1'b1;
                                seg_latch_q <= 1'b1;
                            end else begin
                                bit_q      <= bit_q + 6'd1;
                                seg_sout_q <= frame_q[63];
                                frame_q    <= {frame_q[62:0], 1'b0};
                            end
                        end
                    end
                end
                LATCH: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q       <= '0;
                        seg_latch_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seg_clk   = seg_clk_q;
    assign seg_sout  = seg_sout_q;
    assign seg_latch = seg_latch_q;
    assign seg_clrn  = seg_clrn_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seg7_serial_tx.sv
// Directed bench for seg7_serial_tx: two instances (CLK_DIV=2 and CLK_DIV=1), a bit monitor
// that reassembles frames on seg_clk rises, and a queue of expected frames.
module tb_seg7_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  start;
    logic [31:0] disp;
    logic [7:0]  pt, le;
    logic [1:0]  sclk, ssout, slat, sclrn, sbusy, sdone;

    always #5 clk = ~clk;

    seg7_serial_tx #(.CLK_DIV(2), .BLINK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .Disp_num(disp), .point_in(pt), .LE_in(le),
        .seg_clk(sclk[0]), .seg_sout(ssout[0]), .seg_latch(slat[0]), .seg_clrn(sclrn[0]),
        .busy(sbusy[0]), .done(sdone[0])
    );

    seg7_serial_tx #(.CLK_DIV(1), .BLINK_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .Disp_num(disp), .point_in(pt), .LE_in(le),
        .seg_clk(sclk[1]), .seg_sout(ssout[1]), .seg_latch(slat[1]), .seg_clrn(sclrn[1]),
        .busy(sbusy[1]), .done(sdone[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cyc;
    logic [63:0] exp_q[$];

    // Monitor state, written only by the monitor process.
    logic [63:0] rx_frame [2];
    int   rx_bits [2]   = '{0, 0};
    int   lat_cnt [2]   = '{0, 0};
    int   busy_cnt [2]  = '{0, 0};
    int   done_cnt [2]  = '{0, 0};
    int   done_at [2]   = '{0, 0};
    int   busy_rise [2] = '{0, 0};
    int   viol [2]      = '{0, 0};
    logic p_sclk [2]    = '{1'b0, 1'b0};
    logic p_sout [2]    = '{1'b1, 1'b1};
    logic p_busy [2]    = '{1'b0, 1'b0};

    int s_bits, s_lat, s_busy, s_done;

    // Cycle count since reset release; mirrors the blink counter's time base.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sclk[k] && !p_sclk[k]) begin
                rx_frame[k] = {rx_frame[k][62:0], ssout[k]};
                rx_bits[k]++;
            end
            if (slat[k]) lat_cnt[k]++;
            if (sbusy[k]) busy_cnt[k]++;
            if (sbusy[k] && !p_busy[k]) busy_rise[k] = tb_cyc;
            if (sdone[k]) begin
                done_cnt[k]++;
                done_at[k] = tb_cyc;
            end
            if ((sclk[k] && ssout[k] !== p_sout[k]) || ((slat[k] || !sbusy[k]) && ssout[k] !== 1'b1))
                viol[k]++;
            p_sclk[k] = sclk[k];
            p_sout[k] = ssout[k];
            p_busy[k] = sbusy[k];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] seg_tbl(input logic [3:0] h);
        case (h)
            4'h0: seg_tbl = 8'hC0; 4'h1: seg_tbl = 8'hF9; 4'h2: seg_tbl = 8'hA4; 4'h3: seg_tbl = 8'hB0;
            4'h4: seg_tbl = 8'h99; 4'h5: seg_tbl = 8'h92; 4'h6: seg_tbl = 8'h82; 4'h7: seg_tbl = 8'hF8;
            4'h8: seg_tbl = 8'h80; 4'h9: seg_tbl = 8'h90; 4'hA: seg_tbl = 8'h88; 4'hB: seg_tbl = 8'h83;
            4'hC: seg_tbl = 8'hC6; 4'hD: seg_tbl = 8'hA1; 4'hE: seg_tbl = 8'h86; default: seg_tbl = 8'h8E;
        endcase
    endfunction

    function automatic logic [63:0] exp_frame(input logic [31:0] n, input logic [7:0] p,
                                              input logic [7:0] l, input bit ph);
        logic [63:0] r;
        logic [7:0]  s;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = seg_tbl(n[4*i +: 4]);
            if (l[i] && ph) r[8*i +: 8] = 8'hFF;
            else            r[8*i +: 8] = {~p[i], s[6:0]};
        end
        return r;
    endfunction

    // Blink phase the DUT will capture if start is driven in the current step.
    function automatic bit load_phase();
        return bit'(((tb_cyc + 1) / 4) % 2);
    endfunction

    task automatic kick(input int k, input logic [63:0] exp);
        exp_q.push_back(exp);
        s_bits = rx_bits[k];
        s_lat  = lat_cnt[k];
        s_busy = busy_cnt[k];
        s_done = done_cnt[k];
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 3000 && done_cnt[k] == s_done; i++) step();
    endtask

    task automatic finish_frame(input int k, input int div, input string tag);
        logic [63:0] exp;
        wait_done(k);
        exp = exp_q.pop_front();
        check({tag, "_frame"},   rx_frame[k], exp);
        check({tag, "_bits"},    64'(rx_bits[k] - s_bits), 64'd64);
        check({tag, "_latch"},   64'(lat_cnt[k] - s_lat), 64'(div));
        check({tag, "_busy"},    64'(busy_cnt[k] - s_busy), 64'(1 + 129 * div));
        check({tag, "_latency"}, 64'(done_at[k] - busy_rise[k]), 64'(1 + 129 * div));
        repeat (3) step();
        check({tag, "_done"},    64'(done_cnt[k] - s_done), 64'd1);
    endtask

    initial begin
        int first_done;
        int d0, l0;
        start = 2'b00;
        disp  = 32'h0;
        pt    = 8'h0;
        le    = 8'h0;
        #1 rst = 1'b1;
        repeat (3) step();
        check("reset_dut0", {sclk[0], ssout[0], slat[0], sclrn[0], sbusy[0], sdone[0]}, 6'b010000);
        check("reset_dut1", {sclk[1], ssout[1], slat[1], sclrn[1], sbusy[1], sdone[1]}, 6'b010000);
        rst = 1'b0;
        #1;
        check("clrn_before_edge", sclrn, 2'b00);
        step();
        check("clrn_after_edge", sclrn, 2'b11);

        // Basic frame, CLK_DIV=2.
        disp = 32'h7654_3210;
        kick(0, 64'hF882_9299_B0A4_F9C0);
        finish_frame(0, 2, "basic");

        // All F with decimal point on digit 0.
        disp = 32'hFFFF_FFFF;
        pt   = 8'h01;
        kick(0, 64'h8E8E_8E8E_8E8E_8E0E);
        finish_frame(0, 2, "allf_dp");

        // Mixed pattern with points and blinking digits, expectation from the table model.
        disp = 32'h89AB_CDEF;
        pt   = 8'h5A;
        le   = 8'h24;
        kick(0, exp_frame(disp, pt, le, load_phase()));
        finish_frame(0, 2, "mixed");

        // Blink on digit 7: capture in phase 0, then in phase 1.
        disp = 32'h8888_8888;
        pt   = 8'h00;
        le   = 8'h80;
        for (int i = 0; i < 16 && load_phase() != 1'b0; i++) step();
        kick(0, 64'h8080_8080_8080_8080);
        finish_frame(0, 2, "blink_ph0");
        for (int i = 0; i < 16 && load_phase() != 1'b1; i++) step();
        kick(0, 64'hFF80_8080_8080_8080);
        finish_frame(0, 2, "blink_ph1");

        // start pulsed during SHIFT is ignored; start in the done cycle is accepted.
        disp = 32'h7654_3210;
        le   = 8'h00;
        kick(0, 64'hF882_9299_B0A4_F9C0);
        for (int i = 0; i < 3000; i++) begin
            step();
            if (done_cnt[0] != s_done) break;
            start[0] = (i % 7 == 3) && (rx_bits[0] - s_bits < 60);
        end
        start[0] = 1'b0;
        first_done = done_at[0];
        check("ignore_start_frame", rx_frame[0], exp_q.pop_front());
        check("ignore_start_bits", 64'(rx_bits[0] - s_bits), 64'd64);
        check("ignore_start_done", 64'(done_cnt[0] - s_done), 64'd1);
        kick(0, 64'hF882_9299_B0A4_F9C0);
        check("b2b_load_next_cycle", 64'(busy_rise[0] - first_done), 64'd1);
        finish_frame(0, 2, "b2b");
        d0 = done_cnt[0];
        repeat (300) step();
        check("no_queued_frame", 64'(done_cnt[0] - d0), 64'd0);

        // Reset in the middle of SHIFT discards the frame.
        kick(0, 64'hF882_9299_B0A4_F9C0);
        for (int i = 0; i < 3000 && rx_bits[0] - s_bits < 30; i++) step();
        check("midrst_bit30", 64'(rx_bits[0] - s_bits), 64'd30);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {sclk[0], ssout[0], slat[0], sclrn[0], sbusy[0], sdone[0]}, 6'b010000);
        void'(exp_q.pop_front());
        repeat (2) step();
        rst = 1'b0;
        l0 = lat_cnt[0];
        d0 = done_cnt[0];
        repeat (300) step();
        check("midrst_no_latch", 64'(lat_cnt[0] - l0), 64'd0);
        check("midrst_no_done", 64'(done_cnt[0] - d0), 64'd0);
        kick(0, 64'hF882_9299_B0A4_F9C0);
        finish_frame(0, 2, "after_rst");

        // CLK_DIV=1 instance.
        kick(1, 64'hF882_9299_B0A4_F9C0);
        finish_frame(1, 1, "div1");

        check("sout_rules_dut0", 64'(viol[0]), 64'd0);
        check("sout_rules_dut1", 64'(viol[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_serial_tx.md
SEG7_SERIAL_TX -- requirements
Module: seg7_serial_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per seg_clk half-period (legal range 1..255).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink-phase half-period (legal range >=2).
REQ-003 SHALL have port clk  input  1  single system clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to send one display frame.
REQ-006 SHALL have port Disp_num  input  32  eight hex digits; digit i = Disp_num[4i+3:4i].
REQ-007 SHALL have port point_in  input  8  bit i = 1 lights the decimal point of digit i.
REQ-008 SHALL have port LE_in  input  8  bit i = 1 makes digit i blink.
REQ-009 SHALL have port seg_clk  output  1  serial shift clock to the display shift register.
REQ-010 SHALL have port seg_sout  output  1  serial segment data.
REQ-011 SHALL have port seg_latch  output  1  parallel-load strobe to the display register.
REQ-012 SHALL have port seg_clrn  output  1  display register clear, active-low.
REQ-013 SHALL have port busy  output  1  high while a frame is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH; IDLE->LOAD when start=1; LOAD->SHIFT after 1 cycle; SHIFT->LATCH after 64 bits; LATCH->IDLE after CLK_DIV cycles.
REQ-016 SHALL ignore start in LOAD, SHIFT, LATCH (no queueing).
REQ-017 SHALL in LOAD capture Disp_num, point_in, LE_in and current blink phase into a 64-bit frame = {byte7,...,byte0}.
REQ-018 SHALL encode byte i as {dp,g,f,e,d,c,b,a}, active-low; dp = ~point_in[i].
REQ-019 SHALL use hex table (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E.
REQ-020 SHALL force byte i = FF (digit and dp dark) when LE_in[i]=1 and captured blink phase=1.
REQ-021 SHALL shift frame MSB first (frame[63] first, frame[0] last).
REQ-022 SHALL per bit hold seg_clk=0 for CLK_DIV cycles then 1 for CLK_DIV cycles; seg_sout changes only in the cycle seg_clk goes (or starts) low.
REQ-023 SHALL present frame[63] on seg_sout in the first SHIFT cycle; seg_clk=0 at SHIFT exit.
REQ-024 SHALL hold seg_latch=1 for all CLK_DIV cycles of LATCH, 0 otherwise.
REQ-025 SHALL assert busy in LOAD, SHIFT, LATCH; busy time = 1+129*CLK_DIV cycles.
REQ-026 SHALL pulse done=1 in the first IDLE cycle after LATCH; a start in that same cycle SHALL be accepted.
REQ-027 SHALL run a free-running blink counter 0..BLINK_DIV-1, toggling blink phase on wrap, independent of FSM.
REQ-028 SHALL hold seg_sout=1 in IDLE, LOAD, LATCH.

Reset
REQ-029 SHALL on rst=1 immediately force: state IDLE, seg_clk=0, seg_sout=1, seg_latch=0, seg_clrn=0, busy=0, done=0, blink counter=0, blink phase=0.
REQ-030 SHALL drive seg_clrn=1 from the first clk edge after rst deasserts.
REQ-031 SHALL on rst mid-frame discard the frame; no seg_latch or done is produced for it.

Verification
REQ-032 Reset then start, Disp_num=76543210, point_in=00, LE_in=00, CLK_DIV=2 -> 64 bits on seg_clk rises = F8,82,92,99,B0,A4,F9,C0; seg_latch high 2 cycles; done 259 cycles after LOAD entry.
REQ-033 Disp_num=FFFFFFFF, point_in=01 -> byte0=0E, bytes7..1=8E.
REQ-034 BLINK_DIV=4, LE_in=80, Disp_num=88888888; start in phase 0 then phase 1 -> byte7=80 then FF, others 80 both frames.
REQ-035 start pulsed repeatedly during SHIFT -> exactly one frame, one done; start coincident with done -> second frame begins next cycle.
REQ-036 rst asserted at bit 30 of SHIFT -> outputs at reset values same cycle, no seg_latch, no done; next start sends full 64-bit frame.
REQ-037 CLK_DIV=1 -> seg_clk toggles every cycle, busy 130 cycles, bit order as REQ-032.
